// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: registered ALU with a one-stage valid/ready pipeline and an
// architectural NZCV flag register. ADC/SBC/RSC take their carry-in from the
// flag register; flag writes are gated by the S bit or by a compare opcode.
module alu_pipe_flags #(
   parameter int WIDTH  = 32,
   parameter int PC_INC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic             in_s,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_wen,
   output logic [3:0]       out_flags,
   output logic             out_illegal,
   output logic [3:0]       flags,
   input  logic             flags_ld,
   input  logic [3:0]       flags_din
);

   localparam logic [4:0] OP_AND  = 5'h00;
   localparam logic [4:0] OP_EOR  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_RSB  = 5'h03;
   localparam logic [4:0] OP_ADD  = 5'h04;
   localparam logic [4:0] OP_ADC  = 5'h05;
   localparam logic [4:0] OP_SBC  = 5'h06;
   localparam logic [4:0] OP_RSC  = 5'h07;
   localparam logic [4:0] OP_TST  = 5'h08;
   localparam logic [4:0] OP_TEQ  = 5'h09;
   localparam logic [4:0] OP_CMP  = 5'h0A;
   localparam logic [4:0] OP_CMN  = 5'h0B;
   localparam logic [4:0] OP_ORR  = 5'h0C;
   localparam logic [4:0] OP_MOV  = 5'h0D;
   localparam logic [4:0] OP_BIC  = 5'h0E;
   localparam logic [4:0] OP_MVN  = 5'h0F;
   localparam logic [4:0] OP_PASS = 5'h10;
   localparam logic [4:0] OP_ADDK = 5'h11;
   localparam logic [4:0] OP_ADBK = 5'h12;
   localparam logic [4:0] OP_LSR1 = 5'h13;
   localparam logic [4:0] OP_LSL1 = 5'h14;

   localparam logic [WIDTH-1:0] K_INC = WIDTH'(PC_INC);

   // flag bit positions inside {N,Z,C,V}
   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FC = 1;
   localparam int FV = 0;

   logic             accept;
   logic             carry_flag;

   logic [WIDTH-1:0] add_x;
   logic [WIDTH-1:0] add_y;
   logic [WIDTH-1:0] add_z;
   logic             add_cin;
   logic [WIDTH+1:0] add_s;
   logic             arith_c;
   logic             arith_v;

   logic [WIDTH-1:0] op_result;
   logic             op_c;
   logic             op_v;
   logic             op_legal;
   logic             op_cmp;
   logic             op_wen;
   logic [3:0]       op_flags;
   logic             op_flag_wr;

   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign carry_flag = flags[FC];

   // Operand steering for the shared adder. Subtractions become X + ~Y + cin,
   // so cin=1 gives a plain difference and cin=Cf gives the borrow form.
   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_z   = '0;
      add_cin = 1'b0;
      case (in_op)
         OP_SUB, OP_CMP: begin add_x = in_a; add_y = ~in_b; add_cin = 1'b1;       end
         OP_RSB:         begin add_x = in_b; add_y = ~in_a; add_cin = 1'b1;       end
         OP_ADD, OP_CMN: begin add_x = in_a; add_y = in_b;                        end
         OP_ADC:         begin add_x = in_a; add_y = in_b;  add_cin = carry_flag; end
         OP_SBC:         begin add_x = in_a; add_y = ~in_b; add_cin = carry_flag; end
         OP_RSC:         begin add_x = in_b; add_y = ~in_a; add_cin = carry_flag; end
         OP_ADDK:        begin add_x = in_a; add_y = K_INC;                       end
         OP_ADBK:        begin add_x = in_a; add_y = in_b;  add_z = K_INC;        end
         default:        begin add_x = '0;   add_y = '0;                          end
      endcase
   end

   // One sign-extended adder serves both flags: the top three bits agree only
   // when the signed sum fits in WIDTH bits, and the unsigned carry out of bit
   // WIDTH-1 is recovered by undoing the sign-extension parity at bit WIDTH.
   assign add_s = {{2{add_x[WIDTH-1]}}, add_x}
                + {{2{add_y[WIDTH-1]}}, add_y}
                + {{2{add_z[WIDTH-1]}}, add_z}
                + {{(WIDTH+1){1'b0}}, add_cin};
   assign arith_c = add_s[WIDTH] ^ add_x[WIDTH-1] ^ add_y[WIDTH-1] ^ add_z[WIDTH-1];
   assign arith_v = !((add_s[WIDTH+1] == add_s[WIDTH]) && (add_s[WIDTH] == add_s[WIDTH-1]));

   // Result selection and per-op flag rules; logical ops keep C and V.
   always_comb begin
      op_result = '0;
      op_c      = flags[FC];
      op_v      = flags[FV];
      op_legal  = 1'b1;
      op_cmp    = 1'b0;
      case (in_op)
         OP_AND, OP_TST: op_result = in_a & in_b;
         OP_EOR, OP_TEQ: op_result = in_a ^ in_b;
         OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
         OP_CMP, OP_CMN, OP_ADDK, OP_ADBK: begin
            op_result = add_s[WIDTH-1:0];
            op_c      = arith_c;
            op_v      = arith_v;
         end
         OP_ORR:  op_result = in_a | in_b;
         OP_MOV:  op_result = in_b;
         OP_BIC:  op_result = in_a & ~in_b;
         OP_MVN:  op_result = ~in_b;
         OP_PASS: op_result = in_a;
         OP_LSR1: begin
            op_result = {1'b0, in_a[WIDTH-1:1]};
            op_c      = in_a[0];
         end
         OP_LSL1: begin
            op_result = {in_a[WIDTH-2:0], 1'b0};
            op_c      = in_a[WIDTH-1];
         end
         default: op_legal = 1'b0;
      endcase
      if (in_op == OP_TST || in_op == OP_TEQ || in_op == OP_CMP || in_op == OP_CMN) begin
         op_cmp = 1'b1;
      end
   end

   // Writeback enable, reported flags and flag-register write qualifier.
   always_comb begin
      op_wen     = op_legal && !op_cmp;
      op_flag_wr = op_legal && (in_s || op_cmp);
      op_flags   = flags;
      if (op_legal) begin
         op_flags[FN] = op_result[WIDTH-1];
         op_flags[FZ] = (op_result == '0);
         op_flags[FC] = op_c;
         op_flags[FV] = op_v;
      end
   end

   // Architectural flags: a direct load beats a same-edge flag-writing accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= 4'b0000;
      end else if (flags_ld) begin
         flags <= flags_din;
      end else if (accept && op_flag_wr) begin
         flags <= op_flags;
      end
   end

   // Output stage: load on accept, hold while stalled, drop valid once taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_wen     <= 1'b0;
         out_flags   <= 4'b0000;
         out_illegal <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_result  <= op_result;
         out_wen     <= op_wen;
         out_flags   <= op_flags;
         out_illegal <= !op_legal;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe_flags.sv
// Self-checking bench for alu_pipe_flags: directed scenarios plus a randomized
// run against an arithmetic reference model of the NZCV rules.
module tb_alu_pipe_flags;

   localparam int TW = 32;
   localparam longint SMAX = 64'sh7FFF_FFFF;
   localparam longint SMIN = -SMAX - 1;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_op;
   logic          in_s;
   logic [TW-1:0] in_a;
   logic [TW-1:0] in_b;
   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] out_result;
   logic          out_wen;
   logic [3:0]    out_flags;
   logic          out_illegal;
   logic [3:0]    flags;
   logic          flags_ld;
   logic [3:0]    flags_din;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0]    model_flags;
   logic [TW-1:0] exp_res;
   logic          exp_wen;
   logic [3:0]    exp_flags;
   logic          exp_ill;
   logic          exp_wr;

   alu_pipe_flags #(.WIDTH(TW), .PC_INC(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_s(in_s),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_wen(out_wen), .out_flags(out_flags), .out_illegal(out_illegal),
      .flags(flags), .flags_ld(flags_ld), .flags_din(flags_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // x + y + k + cin with true-value arithmetic
   function automatic void add_ref(input logic [31:0] x, input logic [31:0] y, input int k,
                                   input logic cin, output logic [31:0] r,
                                   output logic c, output logic v);
      longint u;
      longint sd;
      int sx;
      int sy;
      sx = x;
      sy = y;
      u  = longint'(x) + longint'(y) + longint'(k) + longint'(cin);
      sd = longint'(sx) + longint'(sy) + longint'(k) + longint'(cin);
      r  = u[31:0];
      c  = u[32];
      v  = (sd > SMAX) || (sd < SMIN);
   endfunction

   // x - y - (1-cin); C means no borrow
   function automatic void sub_ref(input logic [31:0] x, input logic [31:0] y, input logic cin,
                                   output logic [31:0] r, output logic c, output logic v);
      longint d;
      longint sd;
      int sx;
      int sy;
      sx = x;
      sy = y;
      d  = longint'(x) - longint'(y) - (1 - longint'(cin));
      sd = longint'(sx) - longint'(sy) - (1 - longint'(cin));
      r  = d[31:0];
      c  = (d >= 0);
      v  = (sd > SMAX) || (sd < SMIN);
   endfunction

   function automatic void model_op(input logic [4:0] op, input logic s, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] f,
                                    output logic [31:0] res, output logic wen,
                                    output logic [3:0] of, output logic ill, output logic wr);
      logic c;
      logic v;
      logic cmp;
      c   = f[1];
      v   = f[0];
      res = 32'h0;
      ill = 1'b0;
      cmp = (op >= 5'h08) && (op <= 5'h0B);
      case (op)
         5'h00, 5'h08: res = a & b;
         5'h01, 5'h09: res = a ^ b;
         5'h02, 5'h0A: sub_ref(a, b, 1'b1, res, c, v);
         5'h03:        sub_ref(b, a, 1'b1, res, c, v);
         5'h04, 5'h0B: add_ref(a, b, 0, 1'b0, res, c, v);
         5'h05:        add_ref(a, b, 0, f[1], res, c, v);
         5'h06:        sub_ref(a, b, f[1], res, c, v);
         5'h07:        sub_ref(b, a, f[1], res, c, v);
         5'h0C:        res = a | b;
         5'h0D:        res = b;
         5'h0E:        res = a & ~b;
         5'h0F:        res = ~b;
         5'h10:        res = a;
         5'h11:        add_ref(a, 32'h0, 4, 1'b0, res, c, v);
         5'h12:        add_ref(a, b, 4, 1'b0, res, c, v);
         5'h13: begin res = a >> 1; c = a[0];  end
         5'h14: begin res = a << 1; c = a[31]; end
         default:      ill = 1'b1;
      endcase
      if (ill) begin
         res = 32'h0;
         wen = 1'b0;
         of  = f;
         wr  = 1'b0;
      end else begin
         wen = !cmp;
         of  = {res[31], (res == 32'h0), c, v};
         wr  = s || cmp;
      end
   endfunction

   // Offer one op, wait (bounded) for acceptance, advance to edge+1.
   task automatic drive_op(input logic [4:0] op, input logic s, input logic [31:0] a,
                           input logic [31:0] b);
      int waited;
      waited   = 0;
      in_op    = op;
      in_s     = s;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      #0;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      n_checks++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL accept_timeout: in_ready=%b required 1 after %0d cycles", in_ready, waited);
      end
      model_op(op, s, a, b, model_flags, exp_res, exp_wen, exp_flags, exp_ill, exp_wr);
      $display("op %02h s=%0b a=%08h b=%08h -> res=%08h flags=%04b wen=%0b ill=%0b",
               op, s, a, b, exp_res, exp_flags, exp_wen, exp_ill);
      @(posedge clk); #1;
      if (flags_ld) model_flags = flags_din;
      else if (exp_wr) model_flags = exp_flags;
   endtask

   task automatic test_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", out_result); end
      n_checks++; if (out_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", out_wen); end
      n_checks++; if (out_flags !== 4'b0) begin n_fail++; $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
      n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
      n_checks++; if (flags !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_reset_midstall();
      out_ready = 1'b0;
      drive_op(5'h04, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midstall_valid: got %b want 1", out_valid); end
      n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL midstall_flags: got %b want 0010", flags); end
      @(posedge clk); #1;
      n_checks++; if (out_result !== 32'h1) begin n_fail++; $display("FAIL midstall_hold: got %h want 00000001", out_result); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midstall_in_ready: got %b want 0", in_ready); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
      n_checks++; if (flags !== 4'b0) begin n_fail++; $display("FAIL async_reset_flags: got %b want 0000", flags); end
      n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL async_reset_result: got %h want 0", out_result); end
      @(negedge clk);
      rst_n       = 1'b1;
      model_flags = 4'b0;
      out_ready   = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_carry_chain();
      drive_op(5'h04, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
      n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL chain_add_result: got %h want 0", out_result); end
      n_checks++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL chain_add_flags: got %b want 0110", flags); end
      n_checks++; if (out_flags !== exp_flags) begin n_fail++; $display("FAIL chain_add_out_flags: got %b want %b", out_flags, exp_flags); end
      drive_op(5'h05, 1'b0, 32'h0, 32'h0);
      in_valid = 1'b0;
      n_checks++; if (out_result !== 32'h1) begin n_fail++; $display("FAIL chain_adc_result: got %h want 1", out_result); end
      n_checks++; if (out_result !== exp_res) begin n_fail++; $display("FAIL chain_adc_model: got %h want %h", out_result, exp_res); end
   endtask

   task automatic test_compare();
      drive_op(5'h0A, 1'b0, 32'd5, 32'd7);
      n_checks++; if (out_wen !== 1'b0) begin n_fail++; $display("FAIL cmp_wen: got %b want 0", out_wen); end
      n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL cmp_lt_flags: got %b want 1000", flags); end
      drive_op(5'h0A, 1'b0, 32'd7, 32'd7);
      in_valid = 1'b0;
      n_checks++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL cmp_eq_flags: got %b want 0110", flags); end
      n_checks++; if (out_flags !== 4'b0110) begin n_fail++; $display("FAIL cmp_eq_out_flags: got %b want 0110", out_flags); end
   endtask

   task automatic test_overflow();
      drive_op(5'h04, 1'b1, 32'h7FFF_FFFF, 32'h1);
      n_checks++; if (out_result !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_add_result: got %h want 80000000", out_result); end
      n_checks++; if (flags !== 4'b1001) begin n_fail++; $display("FAIL ovf_add_flags: got %b want 1001", flags); end
      drive_op(5'h02, 1'b1, 32'h8000_0000, 32'h1);
      in_valid = 1'b0;
      n_checks++; if (out_result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ovf_sub_result: got %h want 7fffffff", out_result); end
      n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL ovf_sub_flags: got %b want 0011", flags); end
      n_checks++; if (out_wen !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_wen: got %b want 1", out_wen); end
   endtask

   task automatic test_backpressure();
      logic [31:0] q[$];
      logic [4:0]  ops[4];
      logic [31:0] av[4];
      logic [31:0] bv[4];
      bit          pat[4];
      int          idx;
      int          delivered;
      bit          mv;
      bit          acc;
      bit          del;
      logic [31:0] r;
      logic        w;
      logic [3:0]  f;
      logic        il;
      logic        wr;
      ops = '{5'h04, 5'h01, 5'h03, 5'h0C};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         av[i] = $urandom;
         bv[i] = $urandom;
      end
      idx       = 0;
      delivered = 0;
      mv        = 1'b0;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 40 && delivered < 4; cyc++) begin
         out_ready = pat[cyc % 4];
         if (idx < 4) begin
            in_valid = 1'b1; in_op = ops[idx]; in_s = 1'b0; in_a = av[idx]; in_b = bv[idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         n_checks++;
         if (in_ready !== (!mv || out_ready)) begin
            n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want %b", cyc, in_ready, (!mv || out_ready));
         end
         n_checks++;
         if (out_valid !== mv) begin
            n_fail++; $display("FAIL bp_out_valid: cycle %0d got %b want %b", cyc, out_valid, mv);
         end
         if (mv) begin
            n_checks++;
            if (out_result !== q[0]) begin
               n_fail++; $display("FAIL bp_result: cycle %0d got %h want %h", cyc, out_result, q[0]);
            end
         end
         acc = in_valid && (!mv || out_ready);
         del = mv && out_ready;
         if (del) begin
            $display("bp deliver %0d result=%08h", delivered, q[0]);
            void'(q.pop_front());
            delivered++;
         end
         if (acc) begin
            model_op(ops[idx], 1'b0, av[idx], bv[idx], model_flags, r, w, f, il, wr);
            q.push_back(r);
            idx++;
         end
         mv = acc ? 1'b1 : (del ? 1'b0 : mv);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (delivered != 4) begin
         n_fail++; $display("FAIL bp_delivered: got %0d want 4", delivered);
      end
   endtask

   task automatic test_illegal_and_ld();
      flags_ld  = 1'b1;
      flags_din = 4'b0101;
      @(posedge clk); #1;
      flags_ld    = 1'b0;
      model_flags = 4'b0101;
      n_checks++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL ld_flags: got %b want 0101", flags); end
      drive_op(5'h1F, 1'b1, $urandom, $urandom);
      in_valid = 1'b0;
      n_checks++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b want 1", out_illegal); end
      n_checks++; if (out_wen !== 1'b0) begin n_fail++; $display("FAIL ill_wen: got %b want 0", out_wen); end
      n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL ill_result: got %h want 0", out_result); end
      n_checks++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL ill_flags: got %b want 0101", flags); end
      n_checks++; if (out_flags !== 4'b0101) begin n_fail++; $display("FAIL ill_out_flags: got %b want 0101", out_flags); end
      flags_ld  = 1'b1;
      flags_din = 4'b1111;
      drive_op(5'h04, 1'b1, 32'h1, 32'h1);
      flags_ld = 1'b0;
      n_checks++; if (flags !== 4'b1111) begin n_fail++; $display("FAIL ld_wins_flags: got %b want 1111", flags); end
      n_checks++; if (out_flags !== 4'b0000) begin n_fail++; $display("FAIL ld_wins_out_flags: got %b want 0000", out_flags); end
      drive_op(5'h05, 1'b0, 32'h0, 32'h0);
      in_valid = 1'b0;
      n_checks++; if (out_result !== 32'h1) begin n_fail++; $display("FAIL ld_adc_result: got %h want 1", out_result); end
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (flags !== 4'b1111) begin n_fail++; $display("FAIL idle_flags: got %b want 1111", flags); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners[5];
      int sel;
      corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
      sel = $urandom_range(0, 9);
      return (sel < 5) ? corners[sel] : 32'($urandom);
   endfunction

   task automatic test_random();
      logic [4:0]  op;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  din;
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            in_valid  = 1'b0;
            din       = 4'($urandom);
            flags_ld  = 1'b1;
            flags_din = din;
            @(posedge clk); #1;
            flags_ld    = 1'b0;
            model_flags = din;
            n_checks++; if (flags !== din) begin n_fail++; $display("FAIL rnd_ld_flags: got %b want %b", flags, din); end
         end
         op = 5'($urandom_range(0, 31));
         s  = 1'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         drive_op(op, s, a, b);
         n_checks++; if (out_result !== exp_res) begin n_fail++; $display("FAIL rnd_result op %02h: got %h want %h", op, out_result, exp_res); end
         n_checks++; if (out_flags !== exp_flags) begin n_fail++; $display("FAIL rnd_out_flags op %02h: got %b want %b", op, out_flags, exp_flags); end
         n_checks++; if (out_wen !== exp_wen) begin n_fail++; $display("FAIL rnd_wen op %02h: got %b want %b", op, out_wen, exp_wen); end
         n_checks++; if (out_illegal !== exp_ill) begin n_fail++; $display("FAIL rnd_illegal op %02h: got %b want %b", op, out_illegal, exp_ill); end
         n_checks++; if (flags !== model_flags) begin n_fail++; $display("FAIL rnd_flags op %02h: got %b want %b", op, flags, model_flags); end
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            n_checks++; if (flags !== model_flags) begin n_fail++; $display("FAIL rnd_idle_flags: got %b want %b", flags, model_flags); end
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_op       = 5'h0;
      in_s        = 1'b0;
      in_a        = 32'h0;
      in_b        = 32'h0;
      out_ready   = 1'b1;
      flags_ld    = 1'b0;
      flags_din   = 4'h0;
      model_flags = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset_midstall();
      test_carry_chain();
      test_compare();
      test_overflow();
      test_backpressure();
      test_illegal_and_ld();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_pipe_flags.md
Name: alu_pipe_flags

Overview:
- Parametrised, registered successor to the 32-bit combinational ALU.
- Adds a one-stage valid/ready pipeline and an architectural NZCV flag register.
- ADC/SBC/RSC take their carry-in from the flag register, not from a port; flag updates are conditional on an S bit.
- Sits between operand fetch and writeback in the ARM-style datapath.

Parameters:
WIDTH  32  datapath width in bits, >=8
PC_INC  4  constant used by the A+K and A+B+K ops

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation offered
in_ready  output  1  block can accept operation
in_op  input  5  opcode (see Behaviour)
in_s  input  1  update flags
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
out_valid  output  1  result held
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  registered result
out_wen  output  1  result should be written back (0 for compare ops)
out_flags  output  4  NZCV computed for this op, {N,Z,C,V}
out_illegal  output  1  opcode undefined
flags  output  4  architectural NZCV register
flags_ld  input  1  direct flag write (MSR-style)
flags_din  input  4  value for flags_ld

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_result=0, out_wen=0, out_flags=0, out_illegal=0, flags=0. A transaction in flight is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; result is registered the same edge, so latency is 1 cycle.
  - out_* held stable while out_valid && !out_ready.
  - out_valid clears on the out_ready edge only if no new accept occurs that edge.
  - Back-to-back throughput is 1 op/cycle.
- Opcodes (Cf = flags.C):
  - 00 AND, 01 EOR, 02 SUB A-B, 03 RSB B-A, 04 ADD, 05 ADC A+B+Cf, 06 SBC A-B-!Cf, 07 RSC B-A-!Cf
  - 08 TST (AND), 09 TEQ (EOR), 0A CMP (A-B), 0B CMN (A+B)
  - 0C ORR, 0D MOV B, 0E BIC A&~B, 0F MVN ~B, 10 PASS A, 11 A+PC_INC, 12 A+B+PC_INC
  - 13 LSR1, 14 LSL1
  - 15..1F illegal.
- Arithmetic: computed at WIDTH+1 bits and wraps mod 2^WIDTH.
  - Add ops: C = carry out.
  - Subtract ops: C = NOT borrow, computed as X+~Y+cin.
  - V = signed overflow of the actual operands (minuend/subtrahend order respected).
- Logical ops and MOV/MVN/PASS: C and V keep their previous flag values.
- Shifts: C = bit shifted out (A[0] for LSR1, A[WIDTH-1] for LSL1); V unchanged.
- N = result[WIDTH-1], Z = (result==0) for all legal ops.
- out_flags always reports the flags computed for the op. The flags register is written at accept only when in_s=1 or op is 08..0B.
- out_wen = 0 for 08..0B and for illegal ops, else 1.
- Illegal op: out_result=0, out_wen=0, out_illegal=1, flags register unchanged, out_flags = current flags.
- Carry chaining: an op accepted the cycle after a flag-writing op sees the updated C.
- Simultaneous flags_ld and a flag-writing accept: flags_ld wins.
- Stall: the flags register is not modified while no accept occurs, except by flags_ld.

Test Plan:
1. Reset mid-stall: accept ADD with out_ready=0, assert rst_n=0 -> out_valid=0 and flags=0 immediately, before the next clk edge.
2. ADD, in_s=1, A=FFFFFFFF, B=00000001 -> out_result=0, flags=0110 (Z,C). Next cycle ADC A=0, B=0 -> out_result=1.
3. CMP A=5, B=7 -> out_wen=0, flags N=1 Z=0 C=0 V=0. CMP A=7, B=7 -> flags=0110.
4. ADD, in_s=1, A=7FFFFFFF, B=1 -> 80000000, flags=1001. Then SUB A=80000000, B=1 -> 7FFFFFFF, flags=0011.
5. Backpressure: stream 4 ops with out_ready toggling 1,0,0,1 -> every result delivered once, in order, unchanged while stalled; in_ready low during stalls.
6. Illegal op 1F with in_s=1 -> out_illegal=1, out_wen=0, flags unchanged. Same-cycle flags_ld=1111 with an ADD that has in_s=1 -> flags=1111.
